// File: rtl/classificador_peso_n_if.sv
// Byte-stream input, classified-result output and status of the weight classifier.
// master drives bytes and out_ready; slave is the classifier.
interface classificador_peso_n_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 2
);
  logic                  in_valid;
  logic [7:0]            in_byte;
  logic                  out_ready;
  logic                  out_valid;
  logic [BIN_W-1:0]      out_bin;
  logic [4*DIGITS-1:0]   out_peso;
  logic                  cfg_ok;
  logic                  erro;
  logic [1:0]            erro_cod;
  logic [2:0]            db_estado;

  modport master (
    output in_valid, in_byte, out_ready,
    input  out_valid, out_bin, out_peso, cfg_ok, erro, erro_cod, db_estado
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output out_valid, out_bin, out_peso, cfg_ok, erro, erro_cod, db_estado
  );
endinterface

// File: rtl/classificador_peso_n.sv
// ASCII frame parser and BCD weight binner; result/cfg_ok/erro update on the '#' edge.
// Parser never stalls; a result arriving while the holding register is full is dropped with erro.
module classificador_peso_n #(
  parameter int DIGITS = 4,
  parameter int BINS   = 4,
  parameter int BIN_W  = 2
) (
  input logic clock,
  input logic reset,
  classificador_peso_n_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int DW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(BINS);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
  localparam logic [FW-1:0] FLD_LAST = FW'(BINS - 2);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] CFG_DIG = 3'd1;
  localparam logic [2:0] CFG_FIM = 3'd2;
  localparam logic [2:0] MED_DIG = 3'd3;
  localparam logic [2:0] MED_FIM = 3'd4;

  logic [2:0]        estado;
  logic [DW-1:0]     dig_cnt;
  logic [FW-1:0]     fld_cnt;
  logic [W-1:0]      sombra [BINS-1];
  logic [W-1:0]      limiar [BINS-1];
  logic [W-1:0]      peso;
  logic              ord_falha;
  logic              out_valid;
  logic [BIN_W-1:0]  out_bin;
  logic [W-1:0]      out_peso;
  logic              cfg_ok;
  logic              erro;
  logic [1:0]        erro_cod;

  logic              is_dig;
  logic [3:0]        nib;
  logic [FW-1:0]     fld_ant;
  logic [W-1:0]      campo_novo;
  logic [BIN_W-1:0]  bin_calc;
  logic              consome;

  assign is_dig     = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
  assign nib        = bus.in_byte[3:0];
  assign fld_ant    = fld_cnt - FW'(1);
  assign campo_novo = W'({sombra[fld_cnt], nib});
  assign consome    = out_valid && bus.out_ready;

  // BCD words of equal length order the same as their decimal values.
  always_comb begin
    bin_calc = '0;
    for (int i = 0; i < BINS - 1; i++) begin
      if (peso >= limiar[i]) bin_calc = bin_calc + BIN_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      dig_cnt   <= '0;
      fld_cnt   <= '0;
      peso      <= '0;
      ord_falha <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_peso  <= '0;
      cfg_ok    <= 1'b0;
      erro      <= 1'b0;
      erro_cod  <= 2'd0;
      for (int i = 0; i < BINS - 1; i++) begin
        sombra[i] <= '0;
        limiar[i] <= '0;
      end
    end else begin
      erro     <= 1'b0;
      erro_cod <= 2'd0;
      if (consome) out_valid <= 1'b0;

      if (bus.in_valid) begin
        case (estado)
          OCIOSO: begin
            if (bus.in_byte == 8'h4C) begin
              estado    <= CFG_DIG;
              dig_cnt   <= '0;
              fld_cnt   <= '0;
              ord_falha <= 1'b0;
            end else if (bus.in_byte == 8'h50) begin
              estado  <= MED_DIG;
              dig_cnt <= '0;
            end
          end
          CFG_DIG: begin
            if (is_dig) begin
              sombra[fld_cnt] <= campo_novo;
              if (dig_cnt == DIG_LAST) begin
                dig_cnt <= '0;
                if ((fld_cnt != '0) && (campo_novo < sombra[fld_ant])) ord_falha <= 1'b1;
                if (fld_cnt == FLD_LAST) begin
                  estado  <= CFG_FIM;
                  fld_cnt <= '0;
                end else begin
                  fld_cnt <= fld_cnt + FW'(1);
                end
              end else begin
                dig_cnt <= dig_cnt + DW'(1);
              end
            end else begin
              erro     <= 1'b1;
              erro_cod <= 2'd1;
              estado   <= OCIOSO;
            end
          end
          CFG_FIM: begin
            estado <= OCIOSO;
            if (bus.in_byte != 8'h23) begin
              erro     <= 1'b1;
              erro_cod <= 2'd1;
            end else if (ord_falha) begin
              erro     <= 1'b1;
              erro_cod <= 2'd2;
            end else begin
              limiar <= sombra;
              cfg_ok <= 1'b1;
            end
          end
          MED_DIG: begin
            if (is_dig) begin
              peso <= W'({peso, nib});
              if (dig_cnt == DIG_LAST) begin
                dig_cnt <= '0;
                estado  <= MED_FIM;
              end else begin
                dig_cnt <= dig_cnt + DW'(1);
              end
            end else begin
              erro     <= 1'b1;
              erro_cod <= 2'd1;
              estado   <= OCIOSO;
            end
          end
          MED_FIM: begin
            estado <= OCIOSO;
            if (bus.in_byte != 8'h23) begin
              erro     <= 1'b1;
              erro_cod <= 2'd1;
            end else if (!cfg_ok) begin
              erro     <= 1'b1;
              erro_cod <= 2'd2;
            end else if (!out_valid || consome) begin
              out_valid <= 1'b1;
              out_bin   <= bin_calc;
              out_peso  <= peso;
            end else begin
              erro     <= 1'b1;
              erro_cod <= 2'd3;
            end
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_bin   = out_bin;
  assign bus.out_peso  = out_peso;
  assign bus.cfg_ok    = cfg_ok;
  assign bus.erro      = erro;
  assign bus.erro_cod  = erro_cod;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_classificador_peso_n.sv
// Directed frame table plus random frames checked against a decimal-integer reference model.
module tb_classificador_peso_n;
  localparam int DIGITS = 4;
  localparam int BINS   = 4;
  localparam int BIN_W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  classificador_peso_n_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();
  classificador_peso_n #(.DIGITS(DIGITS), .BINS(BINS), .BIN_W(BIN_W)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input logic v, input logic [7:0] b, input logic rdy);
    bus.in_valid  = v;
    bus.in_byte   = b;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [127:0] frm;
    logic [4:0]   len;
    logic         rdy_b;
    logic         rdy_l;
    logic         e_erro;
    logic [1:0]   e_cod;
    logic         e_vld;
    logic [1:0]   e_bin;
    logic [15:0]  e_peso;
    logic         e_cfg;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input string s, input logic rb, input logic rl, input logic ee,
                              input logic [1:0] ec, input logic ev, input logic [1:0] eb,
                              input logic [15:0] ep, input logic ecf);
    vec_t r;
    r.frm = '0;
    for (int i = 0; i < s.len(); i++) r.frm = {r.frm[119:0], s[i]};
    r.len = 5'(s.len());
    r.rdy_b = rb; r.rdy_l = rl; r.e_erro = ee; r.e_cod = ec;
    r.e_vld = ev; r.e_bin = eb; r.e_peso = ep; r.e_cfg = ecf;
    return r;
  endfunction

  task automatic send_vec(input vec_t v, input int idx);
    int n;
    n = int'(v.len);
    for (int i = 0; i < n; i++)
      tick(1'b1, v.frm[8*(n-1-i) +: 8], (i == n - 1) ? v.rdy_l : v.rdy_b);
    check($sformatf("v%0d_erro", idx), bus.erro, v.e_erro);
    if (v.e_erro) check($sformatf("v%0d_cod", idx), bus.erro_cod, v.e_cod);
    check($sformatf("v%0d_vld", idx), bus.out_valid, v.e_vld);
    if (v.e_vld) begin
      check($sformatf("v%0d_bin", idx), bus.out_bin, v.e_bin);
      check($sformatf("v%0d_peso", idx), bus.out_peso, v.e_peso);
    end
    check($sformatf("v%0d_cfg", idx), bus.cfg_ok, v.e_cfg);
    check($sformatf("v%0d_estado", idx), bus.db_estado, 0);
    tick(1'b0, 8'h00, 1'b0);
    check($sformatf("v%0d_erro_pulse", idx), bus.erro, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"},    bus.out_valid, 0);
    check({tag, "_bin"},    bus.out_bin,   0);
    check({tag, "_peso"},   bus.out_peso,  0);
    check({tag, "_cfg"},    bus.cfg_ok,    0);
    check({tag, "_erro"},   bus.erro,      0);
    check({tag, "_cod"},    bus.erro_cod,  0);
    check({tag, "_estado"}, bus.db_estado, 0);
  endtask

  // Reference model: thresholds as integers, one-deep result holder.
  int          thr[3];
  int          pthr[3];
  bit          mcfg, mheld;
  int          mbin, pbin;
  logic [15:0] mpeso, ppeso;
  logic [7:0]  fq[$];

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void push_num(input int v);
    fq.push_back(8'(48 + v / 1000 % 10));
    fq.push_back(8'(48 + v / 100 % 10));
    fq.push_back(8'(48 + v / 10 % 10));
    fq.push_back(8'(48 + v % 10));
  endfunction

  // ev: 0 none, 1/2 error code, 3 config commit, 4 measurement complete
  task automatic step(input logic v, input logic [7:0] b, input logic rdy, input int ev);
    bit cons, load;
    int ecod;
    cons = mheld && rdy;
    load = 1'b0;
    ecod = 0;
    case (ev)
      1: ecod = 1;
      2: ecod = 2;
      3: begin mcfg = 1'b1; thr = pthr; end
      4: begin
        if (!mcfg) ecod = 2;
        else if (!mheld || cons) load = 1'b1;
        else ecod = 3;
      end
      default: ;
    endcase
    if (load) begin mheld = 1'b1; mbin = pbin; mpeso = ppeso; end
    else if (cons) mheld = 1'b0;
    tick(v, b, rdy);
    check("r_erro", bus.erro, ecod != 0);
    if (ecod != 0) check("r_cod", bus.erro_cod, ecod);
    check("r_vld", bus.out_valid, mheld);
    check("r_cfg", bus.cfg_ok, mcfg);
    if (mheld) begin
      check("r_bin", bus.out_bin, mbin);
      check("r_peso", bus.out_peso, mpeso);
    end
  endtask

  task automatic send_q(input int ev_last);
    for (int i = 0; i < fq.size(); i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 8'h00, $urandom_range(0, 2) == 0, 0);
      step(1'b1, fq[i], $urandom_range(0, 2) == 0, (i == fq.size() - 1) ? ev_last : 0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;

    vt[0]  = mk("P0150#",         1, 1, 1, 2, 0, 0, 16'h0000, 0);
    vt[1]  = mk("L030002000100#", 1, 1, 1, 2, 0, 0, 16'h0000, 0);
    vt[2]  = mk("L010002000300#", 1, 1, 0, 0, 0, 0, 16'h0000, 1);
    vt[3]  = mk("P0150#",         0, 0, 0, 0, 1, 1, 16'h0150, 1);
    vt[4]  = mk("P0099#",         1, 1, 0, 0, 1, 0, 16'h0099, 1);
    vt[5]  = mk("P0100#",         1, 1, 0, 0, 1, 1, 16'h0100, 1);
    vt[6]  = mk("P0300#",         1, 1, 0, 0, 1, 3, 16'h0300, 1);
    vt[7]  = mk("P9999#",         1, 1, 0, 0, 1, 3, 16'h9999, 1);
    vt[8]  = mk("P01A",           1, 1, 1, 1, 0, 0, 16'h0000, 1);
    vt[9]  = mk("7",              1, 1, 0, 0, 0, 0, 16'h0000, 1);
    vt[10] = mk("P0250#",         1, 1, 0, 0, 1, 2, 16'h0250, 1);
    vt[11] = mk("P0050#",         1, 1, 0, 0, 1, 0, 16'h0050, 1);
    vt[12] = mk("P0250#",         0, 0, 1, 3, 1, 0, 16'h0050, 1);
    vt[13] = mk("P0300#",         0, 1, 0, 0, 1, 3, 16'h0300, 1);
    vt[14] = mk("P0050#",         1, 1, 1, 2, 0, 0, 16'h0000, 0);

    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) send_vec(vt[i], i);

    // Reset in the middle of a config frame with a result held.
    tick(1'b1, 8'h4C, 1'b0);
    tick(1'b1, 8'h30, 1'b0);
    tick(1'b1, 8'h31, 1'b0);
    tick(1'b1, 8'h30, 1'b0);
    tick(1'b1, 8'h30, 1'b0);
    check("mid_estado_busy", bus.db_estado != 0, 1);
    rst_n = 1'b0;
    #2;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_vec(vt[14], 14);

    mcfg  = 1'b0;
    mheld = 1'b0;
    for (int f = 0; f < 400; f++) begin
      int r;
      fq.delete();
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        bit ok;
        for (int k = 0; k < 3; k++) pthr[k] = $urandom_range(0, 9999);
        if (r == 0) begin
          for (int a = 0; a < 2; a++)
            for (int k = 0; k < 2 - a; k++)
              if (pthr[k] > pthr[k+1]) begin
                int t;
                t = pthr[k]; pthr[k] = pthr[k+1]; pthr[k+1] = t;
              end
          if ($urandom_range(0, 3) == 0) pthr[1] = pthr[0];
        end
        ok = (pthr[0] <= pthr[1]) && (pthr[1] <= pthr[2]);
        fq.push_back(8'h4C);
        for (int k = 0; k < 3; k++) push_num(pthr[k]);
        fq.push_back(8'h23);
        send_q(ok ? 3 : 2);
      end else if (r <= 6) begin
        int w;
        if (mcfg && $urandom_range(0, 1) == 1) begin
          w = thr[$urandom_range(0, 2)] + int'($urandom_range(0, 2)) - 1;
          if (w < 0) w = 0;
          if (w > 9999) w = 9999;
        end else begin
          w = $urandom_range(0, 9999);
        end
        pbin = 0;
        for (int k = 0; k < 3; k++) if (w >= thr[k]) pbin++;
        ppeso = bcd(w);
        fq.push_back(8'h50);
        push_num(w);
        fq.push_back(8'h23);
        send_q(4);
      end else if (r <= 8) begin
        int ndig, pos;
        logic [7:0] b;
        ndig = ($urandom_range(0, 1) == 1) ? 12 : 4;
        pos  = $urandom_range(0, ndig);
        fq.push_back((ndig == 12) ? 8'h4C : 8'h50);
        for (int k = 0; k < pos; k++) fq.push_back(8'(48 + $urandom_range(0, 9)));
        b = 8'($urandom_range(0, 255));
        if (pos < ndig) begin
          if (b >= 8'h30 && b <= 8'h39) b = b ^ 8'h40;
        end else if (b == 8'h23) begin
          b = 8'h24;
        end
        fq.push_back(b);
        send_q(1);
      end else begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h4C || b == 8'h50) b = 8'h2A;
        fq.push_back(b);
        send_q(0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/classificador_peso_n.md
# classificador_peso_n

Parametrised weight-classification engine for the sorting scale. It consumes the byte stream from the serial receiver (one byte per `in_valid` pulse) and parses ASCII frames. A configuration frame loads `BINS-1` weight thresholds; a measurement frame carries one weight. It bins each measured weight and hands the bin index to the servo-positioning logic through a valid/ready holding register. This replaces the fixed max/min window with N programmable intervals, frame validation and back-pressure.

## Interface
- `DIGITS`, default 4: ASCII decimal digits per weight/threshold field. Values are stored as packed BCD, `4*DIGITS` bits.
- `BINS`, default 4: number of classification bins. `BINS-1` thresholds; must be ≥ 2.
- `BIN_W`, default 2: width of the bin index; `BINS ≤ 2**BIN_W`.
- `clock`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: one-cycle strobe; `in_byte` is valid. Back-to-back strobes are legal.
- `in_byte`  in  8: received ASCII byte.
- `out_ready`  in  1: consumer (servo path) accepts `out_bin`/`out_peso` when high with `out_valid`.
- `out_valid`  out  1: a classification result is held.
- `out_bin`  out  `BIN_W`: bin index of the held result.
- `out_peso`  out  `4*DIGITS`: BCD weight of the held result.
- `cfg_ok`  out  1: a valid threshold set has been committed since reset.
- `erro`  out  1: one-cycle pulse on a rejected frame or dropped result.
- `erro_cod`  out  2: cause, valid with `erro`. 1 = bad character/format; 2 = threshold order or no configuration; 3 = result dropped (overflow).
- `db_estado`  out  3: FSM state encoding, debug only.

## Operation
- Frames:
  - Config: `'L'` (0x4C), then `(BINS-1)*DIGITS` digits `'0'..'9'`, then `'#'` (0x23).
  - Measurement: `'P'` (0x50), then `DIGITS` digits, then `'#'`.
- Each digit is stored as `in_byte - 8'h30` into a left-shifting BCD field register. BCD words of equal length compare as unsigned binary, so no binary conversion is performed.
- FSM states:
  - OCIOSO: `'L'` goes to CFG_DIG; `'P'` goes to MED_DIG. Any other byte is silently ignored; no `erro`.
  - CFG_DIG: shifts digits into a shadow threshold bank. A digit counter runs to `DIGITS-1` and a field counter to `BINS-2`. When the last digit of field k>0 arrives, the completed value is compared against field k-1. If it is smaller, a sticky order-fault flag is set. After the final field, go to CFG_FIM.
  - CFG_FIM: `'#'` with no order fault copies shadow to the live bank, sets `cfg_ok`, and goes to OCIOSO. `'#'` with an order fault gives `erro` code 2, leaves the live bank unchanged, and goes to OCIOSO.
  - MED_DIG: shifts `DIGITS` digits into the weight register, then goes to MED_FIM.
  - MED_FIM: `'#'` classifies the weight and goes to OCIOSO.
- Equal thresholds are legal (an empty bin).
- In CFG_DIG, MED_DIG, CFG_FIM or MED_FIM, an unexpected byte (non-digit, or non-`'#'` terminator) gives `erro` code 1. The partial frame is discarded, the FSM returns to OCIOSO, and the offending byte is not reinterpreted as a frame start.
- Classification: `bin` = number of live thresholds `T_i` with `peso ≥ T_i` (range 0..`BINS-1`), computed combinationally from live thresholds and the completed weight.
- Measurement `'#'` outcomes:
  - With `cfg_ok=0`: `erro` code 2, no result.
  - If the holding register is empty, or is being consumed this cycle (`out_valid & out_ready`): load the result.
  - Otherwise: drop the new result, `erro` code 3, keep the held result unchanged.
- Holding register: `out_valid` clears on `out_valid & out_ready` unless a new result loads in the same cycle. `out_bin`/`out_peso` are stable while `out_valid=1`.

## Timing
- Reset values:
  - All outputs 0, including `out_valid`, `out_bin`, `out_peso`, `cfg_ok`, `erro`, `erro_cod` and `db_estado` (OCIOSO=0).
  - Live and shadow banks, counters and flags cleared.
  - Reset mid-frame abandons the frame; a held result is lost.
- Latency: a terminating `'#'` sampled at edge t gives `out_valid`/`cfg_ok`/`erro` updated at edge t (visible cycle t+1). `erro` is high exactly one cycle.
- New config takes effect for measurements whose `'#'` arrives after the config `'#'` edge.
- Byte throughput: one byte per cycle in every state; no byte is ever stalled or lost by the parser itself.
- Handshake: the transfer occurs at the edge where `out_valid & out_ready`. `out_ready` high with `out_valid=0` has no effect.

## Test plan
- Config `"L010002000300#"` (DIGITS=4, BINS=4) → `cfg_ok=1` at the next edge. Then `"P0150#"` → `out_valid=1`, `out_bin=1`, `out_peso=16'h0150`.
- Boundaries with the above config: `"P0099#"`→0, `"P0100#"`→1, `"P0300#"`→3, `"P9999#"`→3. Consume each with `out_ready=1`.
- `"P0150#"` before any config → `erro` pulse, `erro_cod=2`, `out_valid=0`. Config `"L030002000100#"` → `erro_cod=2`, `cfg_ok` stays 0.
- `"P01A0#"` → `erro_cod=1` on `'A'`, then FSM idle. A following `"P0250#"` → `out_bin=2`. A stray `'7'` in OCIOSO → no `erro`.
- `out_ready=0`; send `"P0050#"` then `"P0250#"` → first held (`out_bin=0`), `erro_cod=3` on the second. Raise `out_ready` on the cycle the third `'#'` arrives → no error, third result loaded.
- Assert `reset` low after `"L0100"` → all outputs 0, `cfg_ok=0`. A subsequent `"P0050#"` → `erro_cod=2`.
